// File: rtl/vga_pattern_gen.sv
// Test-pattern generator for the VGA path: two-stage pipeline from timing-generator
// coordinates to registered {R,G,B}, with frame-synchronous mode and scroll updates.
module vga_pattern_gen #(
   parameter int H_DISP      = 640,
   parameter int V_DISP      = 480,
   parameter int NUM_BARS    = 8,
   parameter int COLOR_W     = 8,
   parameter int CHECK_SHIFT = 5,
   parameter int SCROLL_STEP = 1
) (
   input  logic                   vga_clk,
   input  logic                   sys_rst_n,
   input  logic [9:0]             pixel_xpos,
   input  logic [9:0]             pixel_ypos,
   input  logic [1:0]             mode_sel,
   input  logic                   pause,
   output logic [3*COLOR_W-1:0]   pixel_data,
   output logic                   frame_start,
   output logic [1:0]             mode_active
);

   localparam int          BAR_W    = H_DISP / NUM_BARS;
   localparam int          BAR_H    = V_DISP / NUM_BARS;
   localparam logic [10:0] H_DISP_E = 11'(H_DISP);
   localparam logic [10:0] V_DISP_E = 11'(V_DISP);
   localparam logic [10:0] STEP_E   = 11'(SCROLL_STEP);

   localparam logic [1:0] MODE_STATIC = 2'd0;
   localparam logic [1:0] MODE_SCROLL = 2'd1;
   localparam logic [1:0] MODE_HBARS  = 2'd2;

   // Threshold search instead of division; anything past the last boundary,
   // including the remainder pixels, lands in the last bar.
   function automatic logic [2:0] bar_index(input logic [10:0] e, input int width);
      bar_index = 3'd0;
      for (int k = 1; k < NUM_BARS; k++) begin
         if (int'(e) >= k * width) bar_index = 3'(k);
      end
   endfunction

   function automatic logic [3*COLOR_W-1:0] bar_colour(input logic [2:0] idx);
      logic [COLOR_W-1:0] f;
      logic [COLOR_W-1:0] z;
      f = '1;
      z = '0;
      case (idx)
         3'd0:    bar_colour = {f, f, f};
         3'd1:    bar_colour = {f, f, z};
         3'd2:    bar_colour = {z, f, f};
         3'd3:    bar_colour = {z, f, z};
         3'd4:    bar_colour = {f, z, f};
         3'd5:    bar_colour = {f, z, z};
         3'd6:    bar_colour = {z, z, f};
         default: bar_colour = {z, z, z};
      endcase
   endfunction

   logic [9:0]  x_p1;
   logic [9:0]  y_p1;
   logic        fs_p1;
   logic [9:0]  prev_x;
   logic [9:0]  prev_y;
   logic [9:0]  offset;
   logic        at_origin;
   logic        fs_det;
   logic [10:0] offset_sum;

   assign at_origin  = (pixel_xpos == 10'd0) && (pixel_ypos == 10'd0);
   assign fs_det     = at_origin && !((prev_x == 10'd0) && (prev_y == 10'd0));
   assign offset_sum = {1'b0, offset} + STEP_E;

   // Stage 1: capture coordinates, detect frame start, latch mode and advance scroll.
   always_ff @(posedge vga_clk) begin
      if (!sys_rst_n) begin
         x_p1        <= 10'd0;
         y_p1        <= 10'd0;
         fs_p1       <= 1'b0;
         prev_x      <= 10'h3FF;
         prev_y      <= 10'h3FF;
         mode_active <= MODE_STATIC;
         offset      <= 10'd0;
      end else begin
         x_p1   <= pixel_xpos;
         y_p1   <= pixel_ypos;
         fs_p1  <= fs_det;
         prev_x <= pixel_xpos;
         prev_y <= pixel_ypos;
         if (fs_det) begin
            mode_active <= mode_sel;
            if ((mode_sel == MODE_SCROLL) && !pause) begin
               offset <= (offset_sum >= H_DISP_E) ? 10'(offset_sum - H_DISP_E)
                                                  : offset_sum[9:0];
            end
         end
      end
   end

   logic [10:0]          scroll_sum;
   logic [10:0]          scroll_e;
   logic [9:0]           check_x;
   logic [9:0]           check_y;
   logic [3*COLOR_W-1:0] pixel_next;

   always_comb begin
      scroll_sum = {1'b0, x_p1} + {1'b0, offset};
      scroll_e   = (scroll_sum >= H_DISP_E) ? (scroll_sum - H_DISP_E) : scroll_sum;
      check_x    = x_p1 >> CHECK_SHIFT;
      check_y    = y_p1 >> CHECK_SHIFT;
      pixel_next = '0;
      if (({1'b0, x_p1} < H_DISP_E) && ({1'b0, y_p1} < V_DISP_E)) begin
         case (mode_active)
            MODE_STATIC: pixel_next = bar_colour(bar_index({1'b0, x_p1}, BAR_W));
            MODE_SCROLL: pixel_next = bar_colour(bar_index(scroll_e, BAR_W));
            MODE_HBARS:  pixel_next = bar_colour(bar_index({1'b0, y_p1}, BAR_H));
            default:     pixel_next = (check_x[0] ^ check_y[0]) ? '0 : '1;
         endcase
      end
   end

   // Stage 2: register the pixel and the frame-start marker that goes with it.
   always_ff @(posedge vga_clk) begin
      if (!sys_rst_n) begin
         pixel_data  <= '0;
         frame_start <= 1'b0;
      end else begin
         pixel_data  <= pixel_next;
         frame_start <= fs_p1;
      end
   end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: directed test-plan checks plus randomized coordinates,
// modes, pause and resets compared every cycle against a behavioural model.
module tb_vga_pattern_gen;

   localparam int H_DISP      = 640;
   localparam int V_DISP      = 480;
   localparam int NUM_BARS    = 8;
   localparam int CHECK_SHIFT = 5;
   localparam int SCROLL_STEP = 1;

   logic        vga_clk = 1'b0;
   logic        sys_rst_n;
   logic [9:0]  pixel_xpos;
   logic [9:0]  pixel_ypos;
   logic [1:0]  mode_sel;
   logic        pause;
   logic [23:0] pixel_data;
   logic        frame_start;
   logic [1:0]  mode_active;

   int checks = 0;
   int errors = 0;
   int fs_seen = 0;

   always #5 vga_clk = ~vga_clk;

   vga_pattern_gen #(
      .H_DISP(H_DISP), .V_DISP(V_DISP), .NUM_BARS(NUM_BARS), .COLOR_W(8),
      .CHECK_SHIFT(CHECK_SHIFT), .SCROLL_STEP(SCROLL_STEP)
   ) dut (
      .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pixel_xpos(pixel_xpos),
      .pixel_ypos(pixel_ypos), .mode_sel(mode_sel), .pause(pause),
      .pixel_data(pixel_data), .frame_start(frame_start), .mode_active(mode_active)
   );

   // What a pixel must look like, straight from the pattern rules.
   function automatic logic [23:0] pattern(input int x, input int y, input int mode, input int off);
      int e;
      int bar;
      if (x >= H_DISP || y >= V_DISP) return 24'h000000;
      if (mode == 3)
         return ((((x / (1 << CHECK_SHIFT)) + (y / (1 << CHECK_SHIFT))) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
      if (mode == 2) begin
         bar = y / (V_DISP / NUM_BARS);
      end else begin
         e   = (mode == 1) ? (x + off) % H_DISP : x;
         bar = e / (H_DISP / NUM_BARS);
      end
      if (bar > NUM_BARS - 1) bar = NUM_BARS - 1;
      case (bar)
         0:       return 24'hFFFFFF;
         1:       return 24'hFFFF00;
         2:       return 24'h00FFFF;
         3:       return 24'h00FF00;
         4:       return 24'hFF00FF;
         5:       return 24'hFF0000;
         6:       return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, want, $time);
      end
   endtask

   // Model state: the mode and scroll offset in force for the current frame.
   int          m_mode, m_off, prev_x, prev_y;
   bit          m_fs, model_ok = 1'b0;
   logic [23:0] pend_pix, exp_pix;
   bit          pend_fs, exp_fs;
   int          exp_mode;

   always @(posedge vga_clk) begin
      if (!sys_rst_n) begin
         m_mode   = 0;
         m_off    = 0;
         prev_x   = 1023;
         prev_y   = 1023;
         exp_pix  = 24'h0;
         exp_fs   = 1'b0;
         exp_mode = 0;
         pend_pix = pattern(0, 0, 0, 0);
         pend_fs  = 1'b0;
         model_ok = 1'b1;
      end else begin
         exp_pix = pend_pix;
         exp_fs  = pend_fs;
         m_fs    = (pixel_xpos == 10'd0) && (pixel_ypos == 10'd0) && !(prev_x == 0 && prev_y == 0);
         prev_x  = int'(pixel_xpos);
         prev_y  = int'(pixel_ypos);
         if (m_fs) begin
            m_mode = int'(mode_sel);
            if (mode_sel == 2'd1 && !pause) m_off = (m_off + SCROLL_STEP) % H_DISP;
         end
         pend_pix = pattern(int'(pixel_xpos), int'(pixel_ypos), m_mode, m_off);
         pend_fs  = m_fs;
         exp_mode = m_mode;
      end
   end

   always @(negedge vga_clk) begin
      if (model_ok) begin
         chk("pixel_data", 32'(pixel_data), 32'(exp_pix));
         chk("frame_start", 32'(frame_start), 32'(exp_fs));
         chk("mode_active", 32'(mode_active), 32'(exp_mode));
      end
      if (frame_start) fs_seen++;
   end

   task automatic step(input int x, input int y);
      pixel_xpos = 10'(x);
      pixel_ypos = 10'(y);
      @(posedge vga_clk);
      #1;
   endtask

   task automatic frame();
      step(600, 400);
      step(0, 0);
   endtask

   task automatic pix(input string name, input int x, input int y, input logic [23:0] want);
      step(x, y);
      step(x, y);
      chk(name, 32'(pixel_data), 32'(want));
   endtask

   initial begin
      sys_rst_n  = 1'b0;
      mode_sel   = 2'd0;
      pause      = 1'b0;
      pixel_xpos = 10'd5;
      pixel_ypos = 10'd5;
      step(5, 5);
      step(5, 5);
      chk("rst_pixel", 32'(pixel_data), 32'h0);
      chk("rst_fs", 32'(frame_start), 32'h0);
      chk("rst_mode", 32'(mode_active), 32'h0);

      // Release straight into (0,0): first origin after reset is a frame start.
      sys_rst_n = 1'b1;
      fs_seen   = 0;
      step(0, 0);
      step(1, 0);
      chk("first_fs", 32'(frame_start), 32'h1);
      chk("first_pix", 32'(pixel_data), 32'h00FFFFFF);
      pix("bars_x79", 79, 10, 24'hFFFFFF);
      pix("bars_x80", 80, 10, 24'hFFFF00);
      pix("bars_x639", 639, 10, 24'h000000);
      pix("bars_x640", 640, 10, 24'h000000);
      chk("fs_once", 32'(fs_seen), 32'h1);

      step(300, 10);
      step(301, 10);
      sys_rst_n = 1'b0;
      step(302, 10);
      chk("midline_rst_pix", 32'(pixel_data), 32'h0);
      chk("midline_rst_fs", 32'(frame_start), 32'h0);
      sys_rst_n = 1'b1;

      frame();
      step(100, 200);
      mode_sel = 2'd3;
      step(101, 200);
      step(102, 200);
      step(103, 200);
      chk("mode_held", 32'(mode_active), 32'h0);
      step(639, 479);
      step(0, 0);
      chk("mode_switch", 32'(mode_active), 32'h3);
      pix("chk_31_0", 31, 0, 24'hFFFFFF);
      pix("chk_32_0", 32, 0, 24'h000000);
      pix("chk_32_32", 32, 32, 24'hFFFFFF);

      sys_rst_n = 1'b0;
      step(5, 5);
      sys_rst_n = 1'b1;
      mode_sel  = 2'd1;
      repeat (3) frame();
      pix("scroll3_x77", 77, 5, 24'hFFFF00);
      pix("scroll3_x76", 76, 5, 24'hFFFFFF);
      pause = 1'b1;
      repeat (2) frame();
      pix("pause_x77", 77, 5, 24'hFFFF00);
      pix("pause_x76", 76, 5, 24'hFFFFFF);
      chk("scroll_mode", 32'(mode_active), 32'h1);

      pause = 1'b0;
      repeat (636) frame();
      pix("off639_x1", 1, 5, 24'hFFFFFF);
      pix("off639_x0", 0, 5, 24'h000000);
      frame();
      pix("wrap_x0", 0, 5, 24'hFFFFFF);
      pix("wrap_x80", 80, 5, 24'hFFFF00);

      mode_sel = 2'd2;
      frame();
      pix("hbar_y59", 10, 59, 24'hFFFFFF);
      pix("hbar_y60", 10, 60, 24'hFFFF00);
      pix("hbar_y479", 10, 479, 24'h000000);
      pix("hbar_y480", 10, 480, 24'h000000);
      pix("hbar_x700", 700, 10, 24'h000000);

      repeat (3000) begin
         if ($urandom_range(0, 19) == 0) mode_sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0) pause = ~pause;
         sys_rst_n = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 24) == 0) step(0, 0);
         else step($urandom_range(0, 700), $urandom_range(0, 520));
      end
      sys_rst_n = 1'b1;
      step(10, 10);
      step(11, 10);
      step(12, 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
